// File: rtl/pipelined_dot_acc.sv
// Three-stage valid/ready pipeline: N-lane signed dot product plus bias, then a
// start-or-continue running accumulation with optional saturation.
module pipelined_dot_acc #(
   parameter int unsigned W     = 16,
   parameter int unsigned N     = 2,
   parameter int unsigned ACC_W = 40,
   parameter bit          SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   a_vec,
   input  logic [N*W-1:0]   b_vec,
   input  logic [W-1:0]     bias,
   input  logic             in_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] y,
   output logic             ovf
);

   localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

   logic             s1_valid, s2_valid;
   logic             s1_ready, s2_ready, s3_ready;
   logic [2*W-1:0]   prod    [N];
   logic [2*W-1:0]   s1_prod [N];
   logic [W-1:0]     s1_bias;
   logic             s1_first;
   logic [ACC_W-1:0] sum, s2_sum;
   logic             s2_first;
   logic [ACC_W-1:0] base, res;
   logic [ACC_W:0]   t;
   logic             t_ovf;

   assign s3_ready = !out_valid || out_ready;
   assign s2_ready = !s2_valid || s3_ready;
   assign s1_ready = !s1_valid || s2_ready;
   assign in_ready = s1_ready;

   // Operands are sign-extended to 2W so the truncated product is the exact signed product.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         prod[i] = {{W{a_vec[i*W+W-1]}}, a_vec[i*W +: W]}
                 * {{W{b_vec[i*W+W-1]}}, b_vec[i*W +: W]};
      end
   end

   always_comb begin
      sum = {{(ACC_W-W){s1_bias[W-1]}}, s1_bias};
      for (int unsigned i = 0; i < N; i++) begin
         sum = sum + {{(ACC_W-2*W){s1_prod[i][2*W-1]}}, s1_prod[i]};
      end
   end

   // One guard bit exposes overflow as a mismatch between the top two bits.
   always_comb begin
      base  = s2_first ? '0 : y;
      t     = {base[ACC_W-1], base} + {s2_sum[ACC_W-1], s2_sum};
      t_ovf = t[ACC_W] ^ t[ACC_W-1];
      if (t_ovf && SAT) begin
         res = t[ACC_W] ? AccMin : AccMax;
      end else begin
         res = t[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_bias  <= '0;
         s1_first <= 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            s1_prod[i] <= '0;
         end
      end else if (s1_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_prod  <= prod;
            s1_bias  <= bias;
            s1_first <= in_first;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_first <= 1'b0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum   <= sum;
            s2_first <= s1_first;
         end
      end
   end

   // y doubles as the running accumulator: both take the same value on every accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         ovf       <= 1'b0;
      end else if (s3_ready) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            y   <= res;
            ovf <= t_ovf;
         end
      end
   end

endmodule

// File: doc/pipelined_dot_acc.md
Name: pipelined_dot_acc

Overview:
- Parametrised successor of the team's 3-stage valid/ready multiply-add pipeline.
- Computes an N-lane signed dot product plus a bias, then either starts or continues a running accumulation, selected per transaction.
- Optional saturation with an overflow flag.
- Sits between a streaming sample source and a downstream consumer. Backpressure propagates through the ready chain with no bubbles.

Parameters:
- W, 16: signed width of each operand and of the bias.
- N, 2: number of product lanes (N >= 1).
- ACC_W, 40: signed accumulator and output width. Must be >= 2*W + clog2(N) + 1.
- SAT, 1: 1 = saturate accumulator on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- a_vec  in  N*W  lane i operand a = a_vec[i*W +: W], signed
- b_vec  in  N*W  lane i operand b = b_vec[i*W +: W], signed
- bias  in  W  signed bias, sign-extended
- in_first  in  1  1 = start a new accumulation; 0 = add to the running accumulator
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- y  out  ACC_W  signed result (the running accumulator after this beat)
- ovf  out  1  overflow occurred on this beat (saturated or wrapped)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On assertion, all stage valids, out_valid, y, ovf and the accumulator go to 0 immediately, independent of clk. A beat in flight when reset asserts is discarded.
- Handshakes:
  - A transfer occurs when valid && ready on the same edge.
  - Stage k can accept when its output register is empty or is being drained this cycle.
  - s3_ready = !out_valid || out_ready; s2_ready = !s2_valid || s3_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready.
  - in_ready may depend combinationally on out_ready.
  - Data registers update only on acceptance. They hold while stalled.
- Stage 1: registers the N products p_i = a_i*b_i (2W bits, signed), the sign-extended bias, and in_first.
- Stage 2: s = sum of p_i + bias, computed at ACC_W bits with sign extension. This sum cannot overflow given the ACC_W constraint. in_first is forwarded.
- Stage 3: the accumulation stage.
  - The full sum is t = (first ? 0 : acc) + s, computed at ACC_W+1 bits.
  - Overflow means t lies outside the signed ACC_W range.
  - SAT=1: on overflow, the result clamps to +max or -min according to the sign of t.
  - SAT=0: the result is t truncated to ACC_W bits.
  - y and acc both take the result; ovf takes the overflow indication.
  - acc updates only when a beat is accepted into stage 3. It is unchanged by stalls and by idle cycles.
- Accumulator at first beat: a beat with in_first=0 after reset accumulates onto 0.
- Latency: 3 cycles from input acceptance to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Ordering: beats emerge in order. None are dropped or duplicated under any out_ready pattern.
- out_valid, y and ovf are held stable while out_valid && !out_ready.
- Simultaneous events: drain and fill of the same stage in one cycle is legal and keeps full rate.

Test Plan:
1. Reset, then one beat with W=16, N=2, a=(3,-4), b=(5,6), bias=7, first=1 → 3 cycles later, out_valid=1, y=-2, ovf=0.
2. Four beats back-to-back, out_ready=1, each a=(1,1), b=(2,3), bias=0. Beat 0 has first=1, the rest first=0 → y=5, 10, 15, 20 on consecutive cycles. A fifth beat with first=1 → y=5.
3. Same stream with out_ready toggled 1,0,0,1,0,1… → identical y sequence with no loss or duplication. in_ready drops to 0 once all three stages are full. y is stable during stalls.
4. ACC_W=34, SAT=1: repeat a=(-32768,-32768), b=(-32768,-32768), bias=32767, first=0. Each beat adds 2^31+32767 → after the 4th beat, y saturates at 2^33-1 with ovf=1. The next first=1 beat gives y=2^31+32767, ovf=0. Repeat with SAT=0 → the 4th beat wraps to a negative value with ovf=1.
5. Assert rst asynchronously mid-stream, with two beats in flight and out_valid=1 → out_valid, y and ovf are 0 before the next clk edge. After release, a first=0 beat with a=(2,0), b=(2,0), bias=0 gives y=4, proving acc was cleared.
